bcd_serial_adder: RTL

Parametrised, digit-serial multi-digit BCD adder/subtractor. It accepts two `DIGITS`-digit packed-BCD operands on a `start` pulse and processes one decimal digit per clock, least significant digit first, through a single-digit BCD correction stage. It presents the result with a one-cycle `done` strobe. It feeds the seven-segment display path and the calculator datapath where operands wider than one digit are needed.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 29 ++
 rtl/bcd_serial_adder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with decimal correction and a flag
// for non-decimal operand digits.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c,
  output bcd_digit_t digit,
  output logic       carry,
  output logic       bad
);

  logic [4:0] s;

  // Binary sum, then +6 correction whenever it leaves the decimal range
  always_comb begin
    s = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
    if (s > {1'b0, BCD_MAX}) begin
      digit = 4'(s + {1'b0, BCD_ADJ});
      carry = 1'b1;
    end else begin
      digit = s[3:0];
      carry = 1'b0;
    end
    bad = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first, one digit/clock.
// Optional subtract mode is built only when BCD_SUB_EN is defined; otherwise
// the sub port is ignored and cin always supplies the initial carry.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                hz100,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  bcd_state_t    state, state_nxt;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic          bad_acc;
  logic          cout_q, inv_q;
  logic          init_carry;

  bcd_digit_t    a_d, b_d, b_eff, digit;
  logic          d_carry, d_bad;

  wire accept = (state == IDLE) && start;

  assign a_d = a_q[{idx, 2'b00} +: 4];
  assign b_d = b_q[{idx, 2'b00} +: 4];

`ifdef BCD_SUB_EN
  logic sub_q;

  // Nines-complement of B in subtract mode; an out-of-range B digit stays
  // out of range after complementing, so the bad flag still catches it.
  always_comb begin
    b_eff      = sub_q ? bcd_digit_t'(BCD_MAX - b_d) : b_d;
    init_carry = sub ? 1'b1 : cin;
  end

  // Mode latched with the operands
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset)      sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  // Add-only build: B passes straight through
  always_comb begin
    b_eff      = b_d;
    init_carry = cin;
  end
`endif

  bcd_digit_add u_digit (
    .a_d   (a_d),
    .b_d   (b_eff),
    .c     (carry_q),
    .digit (digit),
    .carry (d_carry),
    .bad   (d_bad)
  );

  // State register
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand latch, digit index, carry chain and result registers
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      bad_acc <= 1'b0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      idx     <= '0;
      carry_q <= init_carry;
      bad_acc <= 1'b0;
    end else if (state == RUN) begin
      sum_q[{idx, 2'b00} +: 4] <= digit;
      carry_q <= d_carry;
      bad_acc <= bad_acc | d_bad;
      if (idx == LAST) begin
        // Flags publish together on the edge that enters DONE
        idx    <= '0;
        cout_q <= d_carry;
        inv_q  <= bad_acc | d_bad;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = inv_q;

endmodule
